hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_hazard_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use/branch stall and flush,
// data-memory wait handling with a timeout ERROR state, and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Match_1E_M,
  input  logic        Match_1E_W,
  input  logic        Match_2E_M,
  input  logic        Match_2E_W,
  input  logic        Match_12D_E,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        PcSrcD,
  input  logic        PcSrcE,
  input  logic        PcSrcM,
  input  logic        PcSrcW,
  input  logic        BranchTakenE,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic        weF,
  output logic        weD,
  output logic        weE,
  output logic        weM,
  output logic        clrD,
  output logic        clrE,
  output logic        clrW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MemErr,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
);

  localparam int WAIT_W = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;

  typedef enum logic {RUN, ERROR} state_t;

  state_t              state_reg, state_next;
  logic [WAIT_W-1:0]   wait_reg, wait_next;
  logic [15:0]         stall_reg, flush_reg;
  logic                ldrstall, pcpend, memwait;

  assign ldrstall = Match_12D_E & MemtoRegE;
  assign pcpend   = PcSrcD | PcSrcE | PcSrcM;
  assign memwait  = MemReqM & ~MemReadyM;

  // Forwarding is state-independent; the M stage holds the younger result so it wins.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!reset) begin
      if (Match_1E_M & RegWriteM)      ForwardAE = 2'b10;
      else if (Match_1E_W & RegWriteW) ForwardAE = 2'b01;
      if (Match_2E_M & RegWriteM)      ForwardBE = 2'b10;
      else if (Match_2E_W & RegWriteW) ForwardBE = 2'b01;
    end
  end

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    weF    = 1'b1;
    weD    = 1'b1;
    weE    = 1'b1;
    weM    = 1'b1;
    clrD   = 1'b0;
    clrE   = 1'b0;
    clrW   = 1'b0;
    MemErr = 1'b0;
    case (state_reg)
      RUN: begin
        if (memwait) begin
          // Freeze the whole pipe and bubble W so a stalled M result is not retired twice.
          weF  = 1'b0;
          weD  = 1'b0;
          weE  = 1'b0;
          weM  = 1'b0;
          clrW = 1'b1;
          wait_next = wait_reg + 1'b1;
          if (wait_reg == WAIT_W'(TIMEOUT - 1)) state_next = ERROR;
        end else begin
          weF  = ~(ldrstall | pcpend);
          weD  = ~ldrstall;
          clrD = pcpend | PcSrcW | BranchTakenE;
          clrE = ldrstall | BranchTakenE;
          wait_next = '0;
        end
      end
      ERROR: begin
        weF    = 1'b0;
        weD    = 1'b0;
        weE    = 1'b0;
        weM    = 1'b0;
        clrD   = 1'b1;
        clrE   = 1'b1;
        clrW   = 1'b1;
        MemErr = 1'b1;
      end
      default: state_next = RUN;
    endcase
    if (reset) begin
      weF    = 1'b1;
      weD    = 1'b1;
      weE    = 1'b1;
      weM    = 1'b1;
      clrD   = 1'b1;
      clrE   = 1'b1;
      clrW   = 1'b1;
      MemErr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      wait_reg  <= '0;
      stall_reg <= '0;
      flush_reg <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      if (!weF && stall_reg != 16'hFFFF)            stall_reg <= stall_reg + 16'd1;
      if ((clrD | clrE) && flush_reg != 16'hFFFF)   flush_reg <= flush_reg + 16'd1;
    end
  end

  assign StallCount = stall_reg;
  assign FlushCount = flush_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a reference model pushes expected outputs per driven
// cycle and a negedge monitor pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  localparam int TO = 4;

  typedef struct packed {
    logic rst, m1m, m1w, m2m, m2w, m12, rwm, rww, mtr;
    logic pd, pe, pm, pw, bt, mreq, mrdy;
  } stim_t;

  typedef struct packed {
    logic [3:0]  we;
    logic [2:0]  clr;
    logic [1:0]  fa, fb;
    logic        err;
    logic [15:0] stall, flush;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic RegWriteM, RegWriteW, MemtoRegE;
  logic PcSrcD, PcSrcE, PcSrcM, PcSrcW, BranchTakenE, MemReqM, MemReadyM;
  logic weF, weD, weE, weM, clrD, clrE, clrW, MemErr;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] StallCount, FlushCount;

  hazard_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
    .Match_12D_E(Match_12D_E), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PcSrcD(PcSrcD), .PcSrcE(PcSrcE), .PcSrcM(PcSrcM),
    .PcSrcW(PcSrcW), .BranchTakenE(BranchTakenE), .MemReqM(MemReqM),
    .MemReadyM(MemReadyM), .weF(weF), .weD(weD), .weE(weE), .weM(weM),
    .clrD(clrD), .clrE(clrE), .clrW(clrW), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .MemErr(MemErr), .StallCount(StallCount),
    .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  bit    quiet = 1'b0;
  exp_t  sb_q[$];
  string tag_q[$];

  // Reference model state
  bit          m_err;
  int          m_wait;
  logic [15:0] m_stall, m_flush;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input stim_t s);
    exp_t e;
    logic ld, pp;
    ld = s.m12 & s.mtr;
    pp = s.pd | s.pe | s.pm;
    e.stall = m_stall;
    e.flush = m_flush;
    e.fa = 2'b00;
    e.fb = 2'b00;
    if (!s.rst) begin
      e.fa = (s.m1m & s.rwm) ? 2'b10 : (s.m1w & s.rww) ? 2'b01 : 2'b00;
      e.fb = (s.m2m & s.rwm) ? 2'b10 : (s.m2w & s.rww) ? 2'b01 : 2'b00;
    end
    if (s.rst) begin
      e.we = 4'b1111; e.clr = 3'b111; e.err = 1'b0;
    end else if (m_err) begin
      e.we = 4'b0000; e.clr = 3'b111; e.err = 1'b1;
    end else if (s.mreq & ~s.mrdy) begin
      e.we = 4'b0000; e.clr = 3'b001; e.err = 1'b0;
    end else begin
      e.we  = {~(ld | pp), ~ld, 1'b1, 1'b1};
      e.clr = {pp | s.pw | s.bt, ld | s.bt, 1'b0};
      e.err = 1'b0;
    end
    return e;
  endfunction

  task automatic step(input string tag, input stim_t s);
    exp_t e;
    reset = s.rst; Match_1E_M = s.m1m; Match_1E_W = s.m1w; Match_2E_M = s.m2m;
    Match_2E_W = s.m2w; Match_12D_E = s.m12; RegWriteM = s.rwm; RegWriteW = s.rww;
    MemtoRegE = s.mtr; PcSrcD = s.pd; PcSrcE = s.pe; PcSrcM = s.pm; PcSrcW = s.pw;
    BranchTakenE = s.bt; MemReqM = s.mreq; MemReadyM = s.mrdy;
    e = model(s);
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    if (s.rst) begin
      m_err = 1'b0; m_wait = 0; m_stall = '0; m_flush = '0;
    end else begin
      if (!m_err) begin
        if (s.mreq & ~s.mrdy) begin
          if (m_wait == TO - 1) m_err = 1'b1;
          m_wait++;
        end else m_wait = 0;
      end
      if (!e.we[3] && m_stall != 16'hFFFF) m_stall++;
      if ((e.clr[2] | e.clr[1]) && m_flush != 16'hFFFF) m_flush++;
    end
    #1;
  endtask

  // Monitor: outputs are settled mid-cycle, well away from the active edge.
  always @(negedge clk) begin
    exp_t  e;
    string t;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".we"},    {28'd0, weF, weD, weE, weM}, {28'd0, e.we});
      check({t, ".clr"},   {29'd0, clrD, clrE, clrW},   {29'd0, e.clr});
      check({t, ".fwdA"},  {30'd0, ForwardAE},          {30'd0, e.fa});
      check({t, ".fwdB"},  {30'd0, ForwardBE},          {30'd0, e.fb});
      check({t, ".err"},   {31'd0, MemErr},             {31'd0, e.err});
      check({t, ".stall"}, {16'd0, StallCount},         {16'd0, e.stall});
      check({t, ".flush"}, {16'd0, FlushCount},         {16'd0, e.flush});
      if (!quiet)
        $display("txn %-10s we=%b%b%b%b clr=%b%b%b fa=%b fb=%b err=%b stall=%0d flush=%0d",
                 t, weF, weD, weE, weM, clrD, clrE, clrW, ForwardAE, ForwardBE,
                 MemErr, StallCount, FlushCount);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s, idle, rst;
    m_err = 1'b0; m_wait = 0; m_stall = '0; m_flush = '0;
    idle = '0;
    rst = '0; rst.rst = 1'b1;
    @(posedge clk); #1;

    step("reset0", rst);
    step("reset1", rst);
    step("idle", idle);

    s = idle; s.m12 = 1; s.mtr = 1;          step("loaduse", s);
    step("idle", idle);

    s = idle; s.m1m = 1; s.m1w = 1; s.rwm = 1; s.rww = 1; step("fwdA_M", s);
    s.rwm = 0;                                            step("fwdA_W", s);
    s.rww = 0;                                            step("fwdA_0", s);
    s = idle; s.m2m = 1; s.m2w = 1; s.rwm = 1; s.rww = 1; step("fwdB_M", s);
    s.rwm = 0;                                            step("fwdB_W", s);
    s = idle; s.m2w = 1; s.rww = 1; s.m1m = 1; s.rwm = 1; step("fwdAB", s);

    s = idle; s.bt = 1; s.m12 = 1; s.mtr = 1; step("br_ld", s);
    s = idle; s.pw = 1;                       step("pcsrcW", s);
    s = idle; s.pd = 1;                       step("pcsrcD", s);
    s = idle; s.pm = 1;                       step("pcsrcM", s);

    s = idle; s.mreq = 1; s.m12 = 1; s.mtr = 1; s.bt = 1;
    for (int i = 0; i < 3; i++) step("memwait", s);
    s.mrdy = 1;                               step("memrdy", s);
    step("idle", idle);

    s = idle; s.mreq = 1; s.m1m = 1; s.rwm = 1;
    for (int i = 0; i < TO; i++) step("wait_to", s);
    step("error", s);
    s.mrdy = 1;
    step("err_rdy", s);
    step("err_rdy", s);
    check("err_persist", {31'd0, MemErr}, 32'd1);
    step("reset", rst);
    step("post_rst", idle);
    step("post_rst", idle);

    quiet = 1'b1;
    for (int i = 0; i < 300; i++) begin
      s = stim_t'($urandom_range(0, 16'hFFFF));
      s.rst = 1'b0;
      if ($urandom_range(0, 3) != 0) s.mreq = 1'b0;
      step("rand", s);
    end
    step("reset", rst);

    s = idle; s.pd = 1;
    for (int i = 0; i < 70000; i++) step("sat", s);
    quiet = 1'b0;
    step("sat_end", s);
    step("sat_idle", idle);
    check("stall_sat", {16'd0, StallCount}, 32'h0000_FFFF);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
